shift_seq: RTL and testbench

Serializing controller that sequences the team's serial shift register. Accepts a parallel word over a valid/ready handshake, captures it, and drives it bit-by-bit, LSB first, onto the shift register's `data_in`. A qualifying strobe accompanies each bit, an optional parity bit follows the word, and a programmable idle gap separates words. It sits between a parallel producer and the `shift_reg` datapath; `ser_out` connects directly to `shift_reg.data_in`.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_seq_cnt.sv | 37 +++
 rtl/shift_seq.sv | 144 ++++++++++++++
 tb/tb_shift_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encodings and counter sizing for shift_seq
//
// Contents:
//   state_t            2-bit FSM state type
//   ST_IDLE..ST_GAP    fixed state encodings 0..3
//   cnt_width()        width of the shared bit/gap counter
package shift_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_PARITY = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    // One counter serves both the bit index and the gap countdown, so it
    // must hold the larger of the two ranges.
    function automatic int cnt_width(input int width, input int gap_cycles);
        int w_bits;
        int w_gap;
        w_bits = $clog2(width + 1);
        w_gap  = $clog2(gap_cycles + 1);
        return (w_bits > w_gap) ? w_bits : w_gap;
    endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// rtl/shift_seq_cnt.sv - clearable up-counter with terminal-count flag
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   clear  in   load zero (wins over inc)
//   inc    in   increment by one
//   last   in   terminal value
//   tc     out  count equals last
module shift_seq_cnt
    import shift_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - parallel-to-serial sequencer feeding shift_reg.data_in
//
// Build option: SHIFT_SEQ_PARITY_EN adds an even-parity bit after each word.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   producer offers in_data
//   in_ready   out  accepting a word this cycle (IDLE)
//   in_data    in   parallel word, captured on handshake
//   ser_out    out  serial bit, LSB first
//   ser_valid  out  ser_out carries payload or parity
//   busy       out  not IDLE
//   done       out  one-cycle pulse after the final serial bit
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int          CW         = cnt_width(WIDTH, GAP_CYCLES);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit          HAS_GAP    = (GAP_CYCLES > 0);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  hold;
    logic              accept;
    logic              cnt_clear;
    logic              cnt_inc;
    logic              cnt_tc;
    logic [CW-1:0]     cnt_last;
    logic              done_nxt;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign cnt_last = (state == ST_GAP) ? GAP_LAST : SHIFT_LAST;

    shift_seq_cnt #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                    cnt_clear = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc) begin
                    cnt_clear = 1'b1;
`ifdef SHIFT_SEQ_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    done_nxt  = 1'b1;
                    state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
`endif
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_PARITY: begin
`ifdef SHIFT_SEQ_PARITY_EN
                done_nxt  = 1'b1;
                state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_GAP: begin
                if (cnt_tc) begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            // The holding register shifts right so bit 0 is always the
            // bit on the wire; in_data is only looked at on accept.
            if (accept) begin
                hold <= in_data;
            end else if (state == ST_SHIFT) begin
                hold <= hold >> 1;
            end
        end
    end

`ifdef SHIFT_SEQ_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^in_data;
        end
    end

    assign ser_valid = (state == ST_SHIFT) || (state == ST_PARITY);
    assign ser_out   = (state == ST_SHIFT)  ? hold[0] :
                       (state == ST_PARITY) ? par     : 1'b0;
`else
    assign ser_valid = (state == ST_SHIFT);
    assign ser_out   = (state == ST_SHIFT) ? hold[0] : 1'b0;
`endif

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking scoreboard bench for shift_seq
module tb_shift_seq;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_valid = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_ser_out, a_ser_valid, a_busy, a_done;

    logic       b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_ser_out, b_ser_valid, b_busy, b_done;

    int         total = 0;
    int         passed = 0;
    int         a_done_cnt = 0;
    int         b_done_cnt = 0;
    logic       qa[$];
    logic       qb[$];

    always #5 clk = ~clk;

    shift_seq #(.WIDTH(8), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
        .busy(a_busy), .done(a_done)
    );

    shift_seq #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input bit to_b, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (to_b) qb.push_back(d[i]);
            else      qa.push_back(d[i]);
        end
        if (P == 1) begin
            if (to_b) qb.push_back(^d);
            else      qa.push_back(^d);
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        int n;
        n = 0;
        while (!a_ready && n < 50) begin
            tick();
            n++;
        end
        chk("a_ready_wait", 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_data  = d;
        push_word(1'b0, d);
        tick();
        a_valid = 1'b0;
    endtask

    // Scoreboard: every serial bit is compared against the queue head.
    always @(negedge clk) begin
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        if (a_ser_valid) begin
            chk("a_q_nonempty", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) chk("a_ser_bit", 32'(a_ser_out), 32'(qa.pop_front()));
        end else begin
            chk("a_ser_out_idle", 32'(a_ser_out), 32'd0);
        end
        if (b_ser_valid) begin
            chk("b_q_nonempty", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) chk("b_ser_bit", 32'(b_ser_out), 32'(qb.pop_front()));
        end else begin
            chk("b_ser_out_idle", 32'(b_ser_out), 32'd0);
        end
    end

    initial begin
        int dcnt;

        // Reset state
        #3;
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_a_ser_valid", 32'(a_ser_valid), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle stability
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ser_valid", 32'(a_ser_valid), 32'd0);
            chk("idle_ser_out", 32'(a_ser_out), 32'd0);
            chk("idle_busy", 32'(a_busy), 32'd0);
            chk("idle_ready", 32'(a_ready), 32'd1);
        end

        // Single word with done / in_ready timing (GAP_CYCLES=1)
        send_a(8'hA5);
        for (int k = 1; k <= 10 + P; k++) begin
            chk("a5_done_timing", 32'(a_done), 32'(k == 9 + P));
            chk("a5_ready_timing", 32'(a_ready), 32'(k == 10 + P));
            tick();
        end
        chk("a5_q_empty", 32'(qa.size()), 32'd0);

        // Parity-sensitive word
        send_a(8'h07);
        repeat (12) tick();
        chk("w07_q_empty", 32'(qa.size()), 32'd0);
        chk("w07_done_cnt", 32'(a_done_cnt), 32'd2);

        // Input isolation: new data and valid pulses during SHIFT
        send_a(8'h5A);
        tick();
        a_data  = 8'hFF;
        a_valid = 1'b1;
        chk("iso_ready_low", 32'(a_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        tick();
        a_valid = 1'b1;
        chk("iso_busy", 32'(a_busy), 32'd1);
        tick();
        a_valid = 1'b0;
        repeat (12) tick();
        chk("iso_q_empty", 32'(qa.size()), 32'd0);
        chk("iso_done_cnt", 32'(a_done_cnt), 32'd3);

        // Back-to-back with GAP_CYCLES=0
        b_valid = 1'b1;
        b_data  = 8'hFF;
        push_word(1'b1, 8'hFF);
        push_word(1'b1, 8'h00);
        tick();
        b_data = 8'h00;
        for (int k = 1; k <= 9 + P; k++) begin
            chk("b2b_done_timing", 32'(b_done), 32'(k == 9 + P));
            if (k == 9 + P) chk("b2b_ready_with_done", 32'(b_ready), 32'd1);
            tick();
        end
        chk("b2b_second_start", 32'(b_ser_valid), 32'd1);
        chk("b2b_second_ready", 32'(b_ready), 32'd0);
        b_valid = 1'b0;
        repeat (12) tick();
        chk("b2b_q_empty", 32'(qb.size()), 32'd0);
        chk("b2b_done_cnt", 32'(b_done_cnt), 32'd2);

        // Reset mid-word after three bits of 0xA5
        send_a(8'hA5);
        tick();
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(a_ready), 32'd1);
        chk("mid_rst_ser_out", 32'(a_ser_out), 32'd0);
        chk("mid_rst_ser_valid", 32'(a_ser_valid), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_done", 32'(a_done), 32'd0);
        chk("mid_rst_bits_seen", 32'(qa.size()), 32'(8 + P - 3));
        qa.delete();
        dcnt = a_done_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_rst_no_done", 32'(a_done_cnt), 32'(dcnt));
        send_a(8'h3C);
        repeat (12) tick();
        chk("w3c_q_empty", 32'(qa.size()), 32'd0);
        chk("w3c_done_cnt", 32'(a_done_cnt), 32'(dcnt + 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
